// File: rtl/cdc_pkg.sv
// Shared definitions for the four-phase req/ack CDC handshake blocks.
// Used by the sender and the matching receiver.
package cdc_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACK_HI  = 3'd2,
        ST_ACK_LO  = 3'd3,
        ST_RECOVER = 3'd4
    } cdc_state_e;

    // Counter width needed to hold 0..timeout, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/cdc_phase_timer.sv
// Per-phase timeout counter: synchronous clear, count enable, expired flag.
// A TIMEOUT_CYCLES of 0 disables expiry entirely.
module cdc_phase_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_expired;

    assign w_expired = (TIMEOUT_CYCLES != 0) &&
                       (r_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    // Saturates at expiry so an unserviced expired flag never wraps back to 0.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !w_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = w_expired;

endmodule

// File: rtl/cdc_handshake_sender.sv
// Source side of a four-phase req/ack handshake carrying one word to another
// clock domain, with a per-phase timeout and sticky error flag.
module cdc_handshake_sender
    import cdc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic [DATA_WIDTH-1:0] xfer_data,
    output logic                  xfer_req,
    input  logic                  ack_sync,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    input  logic                  err_clear
);

    localparam int unsigned CNT_WIDTH = cnt_width(TIMEOUT_CYCLES);

    cdc_state_e            r_state;
    logic                  r_xfer_req;
    logic [DATA_WIDTH-1:0] r_xfer_data;
    logic                  r_done;
    logic                  r_timeout_err;

    cdc_state_e            w_state_nxt;
    logic                  w_req_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  w_done_nxt;
    logic                  w_err_nxt;
    logic                  w_timeout;
    logic                  w_timer_clr;
    logic                  w_timer_en;
    logic                  w_expired;
    logic                  w_s_ready;

    cdc_phase_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_timer_clr),
        .i_enable  (w_timer_en),
        .o_expired (w_expired)
    );

    // A stale ack in IDLE blocks new words until the far side has let go.
    assign w_s_ready = (r_state == ST_IDLE) && !ack_sync && !rst;

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_xfer_req;
        w_data_nxt  = r_xfer_data;
        w_done_nxt  = 1'b0;
        w_timeout   = 1'b0;
        w_timer_clr = 1'b0;
        w_timer_en  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (s_valid && w_s_ready) begin
                    w_data_nxt  = s_data;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_req_nxt   = 1'b1;
                w_timer_clr = 1'b1;
                w_state_nxt = ST_ACK_HI;
            end
            ST_ACK_HI: begin
                if (ack_sync) begin
                    w_req_nxt   = 1'b0;
                    w_timer_clr = 1'b1;
                    w_state_nxt = ST_ACK_LO;
                end else if (w_expired) begin
                    w_req_nxt   = 1'b0;
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RECOVER;
                end else begin
                    w_timer_en = 1'b1;
                end
            end
            ST_ACK_LO: begin
                if (!ack_sync) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RECOVER;
                end else begin
                    w_timer_en = 1'b1;
                end
            end
            ST_RECOVER: begin
                w_req_nxt = 1'b0;
                if (!ack_sync) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Setting wins over a simultaneous clear so no timeout is ever lost.
        if (w_timeout) begin
            w_err_nxt = 1'b1;
        end else if (err_clear) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_timeout_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_xfer_req    <= 1'b0;
            r_xfer_data   <= '0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_xfer_req    <= w_req_nxt;
            r_xfer_data   <= w_data_nxt;
            r_done        <= w_done_nxt;
            r_timeout_err <= w_err_nxt;
        end
    end

    assign s_ready     = w_s_ready;
    assign xfer_data   = r_xfer_data;
    assign xfer_req    = r_xfer_req;
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_cdc_handshake_sender.sv
// Directed bench for cdc_handshake_sender with an 8-cycle phase timeout;
// the far side is driven by hand from the stimulus sequence.
module tb_cdc_handshake_sender;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic [15:0] xfer_data;
    logic        xfer_req;
    logic        ack_sync = 1'b0;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic        err_clear = 1'b0;

    int checks = 0;
    int errors = 0;

    cdc_handshake_sender #(
        .DATA_WIDTH     (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .xfer_data   (xfer_data),
        .xfer_req    (xfer_req),
        .ack_sync    (ack_sync),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .err_clear   (err_clear)
    );

    always #5 clk = ~clk;

    // Advance one edge, then settle away from it before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int          accepts;
    int          last_accept;
    int          bad_gap;
    int          bad_stable;
    logic [15:0] prev_data;
    logic        prev_hold;

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_req", 32'(xfer_req), 32'd0);
        chk("rst_data", 32'(xfer_data), 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready_in_rst", 32'(s_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(s_ready), 32'd1);

        // Basic transfer, far side acks 3 cycles after req and releases 3 after req low
        s_valid = 1'b1;
        s_data  = 16'hA5C3;
        tick();
        s_valid = 1'b0;
        s_data  = 16'h0000;
        chk("basic_data_c1", 32'(xfer_data), 32'hA5C3);
        chk("basic_req_c1", 32'(xfer_req), 32'd0);
        chk("basic_busy_c1", 32'(busy), 32'd1);
        chk("basic_ready_c1", 32'(s_ready), 32'd0);
        tick();
        chk("basic_req_c2", 32'(xfer_req), 32'd1);
        ticks(3);
        chk("basic_req_held", 32'(xfer_req), 32'd1);
        ack_sync = 1'b1;
        tick();
        chk("basic_req_drop", 32'(xfer_req), 32'd0);
        chk("basic_no_done_yet", 32'(done), 32'd0);
        ticks(3);
        chk("basic_busy_ack_lo", 32'(busy), 32'd1);
        ack_sync = 1'b0;
        tick();
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_idle", 32'(busy), 32'd0);
        chk("basic_ready", 32'(s_ready), 32'd1);
        tick();
        chk("basic_done_pulse", 32'(done), 32'd0);
        chk("basic_err", 32'(timeout_err), 32'd0);
        chk("basic_data_hold", 32'(xfer_data), 32'hA5C3);

        // Back-to-back with an immediate-ack far side
        accepts     = 0;
        last_accept = -100;
        bad_gap     = 0;
        bad_stable  = 0;
        s_valid     = 1'b1;
        s_data      = 16'd1;
        prev_data   = xfer_data;
        prev_hold   = 1'b0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (s_valid && s_ready) begin
                accepts++;
                if (cyc - last_accept != 4 && accepts > 1) bad_gap++;
                last_accept = cyc;
            end
            tick();
            if (prev_hold && xfer_data !== prev_data) bad_stable++;
            if (accepts == 3) s_valid = 1'b0;
            else s_data = 16'(accepts + 1);
            ack_sync  = xfer_req;
            prev_data = xfer_data;
            prev_hold = xfer_req || ack_sync;
        end
        ack_sync = 1'b0;
        chk("b2b_accepts", 32'(accepts), 32'd3);
        chk("b2b_gap", 32'(bad_gap), 32'd0);
        chk("b2b_stable", 32'(bad_stable), 32'd0);
        chk("b2b_last_data", 32'(xfer_data), 32'd3);
        chk("b2b_idle", 32'(busy), 32'd0);

        // Ack never arrives: req high 8 cycles, then timeout
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        tick();
        s_valid = 1'b0;
        tick();
        chk("to_req_first", 32'(xfer_req), 32'd1);
        ticks(7);
        chk("to_req_eighth", 32'(xfer_req), 32'd1);
        chk("to_err_not_yet", 32'(timeout_err), 32'd0);
        tick();
        chk("to_req_low", 32'(xfer_req), 32'd0);
        chk("to_err_set", 32'(timeout_err), 32'd1);
        chk("to_busy_recover", 32'(busy), 32'd1);
        chk("to_no_done", 32'(done), 32'd0);
        tick();
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_no_done_idle", 32'(done), 32'd0);
        chk("to_data_hold", 32'(xfer_data), 32'hBEEF);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("to_err_cleared", 32'(timeout_err), 32'd0);

        // Ack stuck high: timeout in WAIT_ACK_LO, then RECOVER until release
        s_valid = 1'b1;
        s_data  = 16'h1234;
        tick();
        s_valid = 1'b0;
        tick();
        ack_sync = 1'b1;
        tick();
        chk("stk_req_low", 32'(xfer_req), 32'd0);
        ticks(7);
        chk("stk_err_not_yet", 32'(timeout_err), 32'd0);
        tick();
        chk("stk_err_set", 32'(timeout_err), 32'd1);
        chk("stk_no_done", 32'(done), 32'd0);
        ticks(3);
        chk("stk_recover_busy", 32'(busy), 32'd1);
        chk("stk_recover_ready", 32'(s_ready), 32'd0);
        chk("stk_recover_req", 32'(xfer_req), 32'd0);
        ack_sync = 1'b0;
        tick();
        chk("stk_idle", 32'(busy), 32'd0);
        chk("stk_idle_no_done", 32'(done), 32'd0);
        chk("stk_err_sticky", 32'(timeout_err), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("stk_err_cleared", 32'(timeout_err), 32'd0);

        // Stale ack in IDLE blocks acceptance without flagging an error
        ack_sync = 1'b1;
        s_valid  = 1'b1;
        s_data   = 16'hFFFF;
        #1;
        chk("stale_ready", 32'(s_ready), 32'd0);
        ticks(2);
        chk("stale_busy", 32'(busy), 32'd0);
        chk("stale_data", 32'(xfer_data), 32'h1234);
        chk("stale_err", 32'(timeout_err), 32'd0);
        s_valid  = 1'b0;
        ack_sync = 1'b0;
        #1;
        chk("stale_ready_back", 32'(s_ready), 32'd1);

        // Timeout and err_clear on the same edge: set wins
        s_valid = 1'b1;
        s_data  = 16'h5A5A;
        tick();
        s_valid = 1'b0;
        ticks(8);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("coll_err", 32'(timeout_err), 32'd1);
        tick();
        chk("coll_idle", 32'(busy), 32'd0);

        // Reset mid-handshake in WAIT_ACK_HI, with the error still set
        s_valid = 1'b1;
        s_data  = 16'hC0DE;
        tick();
        s_valid = 1'b0;
        tick();
        chk("mrst_req_before", 32'(xfer_req), 32'd1);
        ack_sync = 1'b1;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_req", 32'(xfer_req), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_err", 32'(timeout_err), 32'd0);
        chk("mrst_data", 32'(xfer_data), 32'h0);
        chk("mrst_ready_ack_hi", 32'(s_ready), 32'd0);
        ack_sync = 1'b0;
        #1;
        chk("mrst_ready_ack_lo", 32'(s_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
